sys_tile_scheduler: RTL and testbench

- Walks the tile loop nest of an (ROW_M x COL_M) * (COL_M x COL_N) matrix multiply on the TILE x TILE systolic array.
- For each tile it issues a one-cycle go to the array sequencer and waits for its completion.
- For each tile it also presents tile indices, operand/result tile base indices and accumulate-clear/flush qualifiers.
- Sits between the host/command interface and the array sequencer; k is the innermost loop, then n, then m.

---
 rtl/sys_tile_scheduler_pkg.sv | 40 ++++
 rtl/sys_tile_idx_counter.sv | 72 +++++++
 rtl/sys_tile_scheduler.sv | 126 ++++++++++++
 tb/tb_sys_tile_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_tile_scheduler_pkg.sv
// Shared types and helpers for the GEMM tile scheduler.
// State encoding, tile-count derivation and dimension sanity check.
package sys_tile_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_e;

    localparam int unsigned TILE_DEF  = 8;
    localparam int unsigned ROW_M_DEF = 16;
    localparam int unsigned COL_M_DEF = 16;
    localparam int unsigned COL_N_DEF = 24;

    function automatic int unsigned ntiles(
        input int unsigned dim,
        input int unsigned tile
    );
        return dim / tile;
    endfunction

    function automatic bit dims_ok(
        input int unsigned tile,
        input int unsigned rm,
        input int unsigned cm,
        input int unsigned cn
    );
        if (tile == 0) return 1'b0;
        if (rm == 0 || cm == 0 || cn == 0) return 1'b0;
        return (rm % tile == 0) && (cm % tile == 0) && (cn % tile == 0);
    endfunction

    localparam int unsigned NT_M_DEF = ROW_M_DEF / TILE_DEF;
    localparam int unsigned NT_K_DEF = COL_M_DEF / TILE_DEF;
    localparam int unsigned NT_N_DEF = COL_N_DEF / TILE_DEF;

endpackage

// File: rtl/sys_tile_idx_counter.sv
// Nested m/n/k tile index counter; k is innermost, m outermost.
// last_o flags the final tile of the loop nest.
module sys_tile_idx_counter #(
    parameter int unsigned NT_M  = 2,
    parameter int unsigned NT_N  = 3,
    parameter int unsigned NT_K  = 2,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] m_o,
    output logic [IDX_W-1:0] n_o,
    output logic [IDX_W-1:0] k_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] M_MAX = IDX_W'(NT_M - 1);
    localparam logic [IDX_W-1:0] N_MAX = IDX_W'(NT_N - 1);
    localparam logic [IDX_W-1:0] K_MAX = IDX_W'(NT_K - 1);

    logic [IDX_W-1:0] m_q, m_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             m_last, n_last, k_last;

    assign m_last = (m_q == M_MAX);
    assign n_last = (n_q == N_MAX);
    assign k_last = (k_q == K_MAX);

    always_comb begin
        m_d = m_q;
        n_d = n_q;
        k_d = k_q;
        if (clr_i) begin
            m_d = '0;
            n_d = '0;
            k_d = '0;
        end else if (inc_i) begin
            if (k_last) begin
                k_d = '0;
                if (n_last) begin
                    n_d = '0;
                    m_d = m_last ? '0 : m_q + 1'b1;
                end else begin
                    n_d = n_q + 1'b1;
                end
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q <= '0;
            n_q <= '0;
            k_q <= '0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
            k_q <= k_d;
        end
    end

    assign m_o    = m_q;
    assign n_o    = n_q;
    assign k_o    = k_q;
    assign last_o = m_last & n_last & k_last;

endmodule

// File: rtl/sys_tile_scheduler.sv
// Tile loop-nest scheduler for a TILE x TILE systolic GEMM array.
// Issues one go per tile, waits for completion, tracks bases and counts.
module sys_tile_scheduler
    import sys_tile_scheduler_pkg::*;
#(
    parameter int unsigned TILE  = 8,
    parameter int unsigned ROW_M = 16,
    parameter int unsigned COL_M = 16,
    parameter int unsigned COL_N = 24,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             tile_done,
    output logic             tile_go,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] tile_m,
    output logic [IDX_W-1:0] tile_n,
    output logic [IDX_W-1:0] tile_k,
    output logic [IDX_W-1:0] a_base,
    output logic [IDX_W-1:0] w_base,
    output logic [IDX_W-1:0] c_base,
    output logic             acc_clear,
    output logic             acc_flush,
    output logic [CNT_W-1:0] tiles_done
);

    localparam int unsigned NT_M = ntiles(ROW_M, TILE);
    localparam int unsigned NT_K = ntiles(COL_M, TILE);
    localparam int unsigned NT_N = ntiles(COL_N, TILE);

    localparam logic [IDX_W-1:0] NTK_C = IDX_W'(NT_K);
    localparam logic [IDX_W-1:0] NTN_C = IDX_W'(NT_N);
    localparam logic [IDX_W-1:0] K_MAX = IDX_W'(NT_K - 1);

    if (!dims_ok(TILE, ROW_M, COL_M, COL_N)) begin : g_dim_chk
        $error("matrix dimensions must be nonzero multiples of TILE");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tiles_q, tiles_d;
    logic             cnt_clr, cnt_inc, last;
    logic [IDX_W-1:0] m, n, k;

    sys_tile_idx_counter #(
        .NT_M  (NT_M),
        .NT_N  (NT_N),
        .NT_K  (NT_K),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .m_o    (m),
        .n_o    (n),
        .k_o    (k),
        .last_o (last)
    );

    // Abort outranks everything, including a coincident tile_done.
    always_comb begin
        state_d = state_q;
        tiles_d = tiles_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_ISSUE;
                        cnt_clr = 1'b1;
                        tiles_d = '0;
                    end
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (tile_done) state_d = S_ADVANCE;
                end
                S_ADVANCE: begin
                    tiles_d = tiles_q + 1'b1;
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tiles_q <= '0;
        end else begin
            state_q <= state_d;
            tiles_q <= tiles_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign tile_go    = (state_q == S_ISSUE);
    assign done       = (state_q == S_DONE);
    assign tile_m     = m;
    assign tile_n     = n;
    assign tile_k     = k;
    assign a_base     = m * NTK_C + k;
    assign w_base     = k * NTN_C + n;
    assign c_base     = m * NTN_C + n;
    // Qualifiers only mean something while a GEMM is in flight.
    assign acc_clear  = busy && (k == '0);
    assign acc_flush  = busy && (k == K_MAX);
    assign tiles_done = tiles_q;

endmodule

// File: tb/tb_sys_tile_scheduler.sv
// Scoreboard bench for sys_tile_scheduler: default 2x2x3 nest plus
// a single-tile instance for the degenerate case and async reset.
module tb_sys_tile_scheduler;

    localparam int IDX_W = 8;
    localparam int CNT_W = 16;

    typedef struct {
        int m; int n; int k;
        int a; int w; int c;
        int clr; int fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic start = 1'b0, abort = 1'b0;
    logic resp_done = 1'b0, spur_done = 1'b0;
    logic tile_done;
    assign tile_done = resp_done | spur_done;
    logic tile_go, busy, done, acc_clear, acc_flush;
    logic [IDX_W-1:0] tile_m, tile_n, tile_k, a_base, w_base, c_base;
    logic [CNT_W-1:0] tiles_done;

    logic start1 = 1'b0, abort1 = 1'b0, tile_done1 = 1'b0;
    logic tile_go1, busy1, done1, acc_clear1, acc_flush1;
    logic [IDX_W-1:0] tile_m1, tile_n1, tile_k1, a_base1, w_base1, c_base1;
    logic [CNT_W-1:0] tiles_done1;

    sys_tile_scheduler dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort),
        .tile_done(tile_done), .tile_go(tile_go), .busy(busy),
        .done(done), .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k),
        .a_base(a_base), .w_base(w_base), .c_base(c_base),
        .acc_clear(acc_clear), .acc_flush(acc_flush),
        .tiles_done(tiles_done)
    );

    sys_tile_scheduler #(
        .TILE(8), .ROW_M(8), .COL_M(8), .COL_N(8)
    ) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .abort(abort1),
        .tile_done(tile_done1), .tile_go(tile_go1), .busy(busy1),
        .done(done1), .tile_m(tile_m1), .tile_n(tile_n1),
        .tile_k(tile_k1), .a_base(a_base1), .w_base(w_base1),
        .c_base(c_base1), .acc_clear(acc_clear1),
        .acc_flush(acc_flush1), .tiles_done(tiles_done1)
    );

    exp_t exp_q[$], exp1_q[$];
    int done_q[$], done1_q[$];
    int go_cyc[$];
    int checks = 0, errors = 0;
    int go_count = 0, done_count = 0, go1_count = 0, done1_count = 0;
    int last_td = 0, done_cyc = 0;
    int resp_dly = 5;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endfunction

    function automatic void push_tiles(int nm, int nn, int nk, int cnt);
        int i = 0;
        for (int m = 0; m < nm; m++)
            for (int n = 0; n < nn; n++)
                for (int k = 0; k < nk; k++) begin
                    if (i < cnt)
                        exp_q.push_back('{m, n, k, m*nk+k, k*nn+n, m*nn+n,
                                          int'(k == 0), int'(k == nk-1)});
                    i++;
                end
    endfunction

    // Monitor: pops expectations whenever a DUT presents go or done.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (tile_go) begin
            go_count++;
            go_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("go_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("tile_m", tile_m, e.m);
                chk("tile_n", tile_n, e.n);
                chk("tile_k", tile_k, e.k);
                chk("a_base", a_base, e.a);
                chk("w_base", w_base, e.w);
                chk("c_base", c_base, e.c);
                chk("acc_clear", acc_clear, e.clr);
                chk("acc_flush", acc_flush, e.fl);
                chk("busy_in_go", busy, 1);
            end
        end
        if (tile_done) last_td = cyc;
        if (done) begin
            done_count++;
            done_cyc = cyc;
            chk("busy_in_done", busy, 1);
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_tiles", tiles_done, done_q.pop_front());
        end
        if (tile_go1) begin
            go1_count++;
            if (exp1_q.size() == 0) chk("go1_unexpected", 1, 0);
            else begin
                e = exp1_q.pop_front();
                chk("t1_idx", {tile_m1, tile_n1, tile_k1}, 0);
                chk("t1_bases", {a_base1, w_base1, c_base1}, 0);
                chk("t1_clear", acc_clear1, e.clr);
                chk("t1_flush", acc_flush1, e.fl);
            end
        end
        if (done1) begin
            done1_count++;
            if (done1_q.size() == 0) chk("done1_unexpected", 1, 0);
            else chk("done1_tiles", tiles_done1, done1_q.pop_front());
        end
    end

    // Array-sequencer model: replies resp_dly cycles after each go.
    initial forever begin
        @(negedge clk);
        if (tile_go) begin
            repeat (resp_dly) @(posedge clk);
            #1 resp_done = 1'b1;
            @(posedge clk);
            #1 resp_done = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(int target, int budget);
        int b = 0;
        while (done_count < target && b < budget) begin
            tick(1);
            b++;
        end
        chk("wait_done", done_count >= target, 1);
    endtask

    task automatic wait_go(int target, int budget);
        int b = 0;
        while (go_count < target && b < budget) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk("wait_go", go_count >= target, 1);
    endtask

    initial begin
        int st, g0, dc;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_go", tile_go, 0);
        chk("rst_done", done, 0);
        chk("rst_clear", acc_clear, 0);
        chk("rst_flush1", acc_flush1, 0);
        chk("rst_tiles", tiles_done, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Run A: slow replies, full sequence and bases.
        resp_dly = 5;
        push_tiles(2, 3, 2, 12);
        done_q.push_back(12);
        go_cyc.delete();
        g0 = go_count;
        st = cyc;
        pulse_start();
        wait_done(1, 400);
        chk("first_go_lat", go_cyc.size() > 0 ? go_cyc[0] - st : -1, 1);
        chk("go_count_A", go_count - g0, 12);
        chk("done_lat_A", done_cyc - last_td, 2);
        chk("busy_after_done", busy, 0);
        chk("final_idx", {tile_m, tile_n, tile_k}, {8'd1, 8'd2, 8'd1});
        chk("final_bases", {a_base, w_base, c_base}, {8'd3, 8'd5, 8'd5});
        chk("tiles_A", tiles_done, 12);

        // Run B: immediate replies, go period of 3.
        resp_dly = 1;
        tick(3);
        push_tiles(2, 3, 2, 12);
        done_q.push_back(12);
        go_cyc.delete();
        pulse_start();
        wait_done(2, 400);
        chk("go_count_B", go_cyc.size(), 12);
        for (int i = 1; i < go_cyc.size(); i++)
            chk("go_period", go_cyc[i] - go_cyc[i-1], 3);
        chk("done_lat_B", done_cyc - last_td, 2);

        // Run C: abort in WAIT of tile 7, then clean restart.
        resp_dly = 5;
        tick(3);
        push_tiles(2, 3, 2, 7);
        g0 = go_count;
        pulse_start();
        wait_go(g0 + 7, 300);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tiles", tiles_done, 6);
        chk("abort_idx", {tile_m, tile_n, tile_k}, 0);
        dc = done_count;
        tick(12);
        chk("abort_no_done", done_count, dc);
        push_tiles(2, 3, 2, 12);
        done_q.push_back(12);
        g0 = go_count;
        pulse_start();
        wait_done(dc + 1, 400);
        chk("go_count_C", go_count - g0, 12);

        // Run D: spurious tile_done in ISSUE and start while busy.
        tick(3);
        push_tiles(2, 3, 2, 12);
        done_q.push_back(12);
        g0 = go_count;
        dc = done_count;
        pulse_start();
        wait_go(g0 + 3, 300);
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        wait_go(g0 + 5, 300);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(dc + 1, 400);
        chk("go_count_D", go_count - g0, 12);
        chk("tiles_D", tiles_done, 12);

        // Single-tile instance: one go with clear and flush, then done.
        tick(3);
        exp1_q.push_back('{0, 0, 0, 0, 0, 0, 1, 1});
        done1_q.push_back(1);
        g0 = go1_count;
        dc = done1_count;
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        for (int b = 0; b < 20 && go1_count == g0; b++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 tile_done1 = 1'b1;
        tick(1);
        tile_done1 = 1'b0;
        for (int b = 0; b < 20 && done1_count == dc; b++) tick(1);
        chk("single_done", done1_count - dc, 1);
        tick(4);
        chk("single_go", go1_count - g0, 1);

        // Async reset in WAIT of the single-tile instance.
        exp1_q.push_back('{0, 0, 0, 0, 0, 0, 1, 1});
        g0 = go1_count;
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        for (int b = 0; b < 20 && go1_count == g0; b++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #3 chk("pre_rst_busy1", busy1, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy1", busy1, 0);
        chk("arst_go1", tile_go1, 0);
        chk("arst_clear1", acc_clear1, 0);
        chk("arst_flush1", acc_flush1, 0);
        chk("arst_tiles1", tiles_done1, 0);
        chk("arst_tiles", tiles_done, 0);
        dc = done1_count;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("arst_no_done", done1_count, dc);

        chk("exp_q_empty", exp_q.size(), 0);
        chk("exp1_q_empty", exp1_q.size(), 0);
        chk("done_q_empty", done_q.size() + done1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
